// File: rtl/inv_factorial_seq.sv
// -----------------------------------------------------------------------------
// inv_factorial_seq
//
// Sequential inverse-factorial finder. For an unsigned operand V it walks the
// factorial sequence (1!, 2!, 3!, ...) one multiply per clock. It reports the
// largest n with n! <= V, whether V is exactly n!, and an error flag when V == 0.
// A start/done handshake drives it.
//
// Optional build macro: INV_FACT_REM_EN
//   When defined, it adds the rem output and its register, which holds V - n_out!.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only while idle
//   value  in   operand V [WIDTH], latched on an accepted start
//   busy   out  high in CALC and DONE
//   done   out  one-cycle completion pulse
//   n_out  out  result n [CNT_W], held until the next result
//   exact  out  V == n_out!
//   err    out  V == 0 (no valid n)
//   rem    out  V - n_out! [WIDTH] (INV_FACT_REM_EN only)
// -----------------------------------------------------------------------------
module inv_factorial_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] n_out,
    output logic             exact,
    output logic             err
`ifdef INV_FACT_REM_EN
    ,
    output logic [WIDTH-1:0] rem
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   k_reg, k_next;
    logic [WIDTH-1:0]   vreg_reg, vreg_next;
    logic [CNT_W-1:0]   n_out_reg, n_out_next;
    logic               exact_reg, exact_next;
    logic               err_reg, err_next;
`ifdef INV_FACT_REM_EN
    logic [WIDTH-1:0]   rem_reg, rem_next;
`endif

    // The candidate (k+1)! is formed at double width. A product that passes
    // 2^WIDTH-1 therefore compares as "too big". It cannot wrap into a small
    // value that would look valid.
    logic [CNT_W-1:0]   k_inc;
    logic [2*WIDTH-1:0] nxt;

    assign k_inc = k_reg + 1'b1;
    assign nxt   = {{WIDTH{1'b0}}, acc_reg} * {{(2*WIDTH-CNT_W){1'b0}}, k_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= {{(WIDTH-1){1'b0}}, 1'b1};
            k_reg     <= {{(CNT_W-1){1'b0}}, 1'b1};
            vreg_reg  <= '0;
            n_out_reg <= '0;
            exact_reg <= 1'b0;
            err_reg   <= 1'b0;
`ifdef INV_FACT_REM_EN
            rem_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            k_reg     <= k_next;
            vreg_reg  <= vreg_next;
            n_out_reg <= n_out_next;
            exact_reg <= exact_next;
            err_reg   <= err_next;
`ifdef INV_FACT_REM_EN
            rem_reg   <= rem_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        k_next     = k_reg;
        vreg_next  = vreg_reg;
        n_out_next = n_out_reg;
        exact_next = exact_reg;
        err_next   = err_reg;
`ifdef INV_FACT_REM_EN
        rem_next   = rem_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    vreg_next = value;
                    acc_next  = {{(WIDTH-1){1'b0}}, 1'b1};
                    k_next    = {{(CNT_W-1){1'b0}}, 1'b1};
                    if (value == '0) begin
                        // V == 0 has no valid n. Skip the search entirely.
                        state_next = DONE;
                        n_out_next = '0;
                        exact_next = 1'b0;
                        err_next   = 1'b1;
`ifdef INV_FACT_REM_EN
                        rem_next   = '0;
`endif
                    end else begin
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                // Stop as soon as the next factorial passes V. The search
                // starts at k=1, so V == 1 resolves to n=1 and not to n=0.
                if (nxt > {{WIDTH{1'b0}}, vreg_reg}) begin
                    state_next = DONE;
                    n_out_next = k_reg;
                    exact_next = (acc_reg == vreg_reg);
                    err_next   = 1'b0;
`ifdef INV_FACT_REM_EN
                    rem_next   = vreg_reg - acc_reg;
`endif
                end else begin
                    acc_next = nxt[WIDTH-1:0];
                    k_next   = k_inc;
                end
            end
            DONE: begin
                // A start that arrives alongside done is dropped on purpose.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy  = (state_reg != IDLE);
    assign done  = (state_reg == DONE);
    assign n_out = n_out_reg;
    assign exact = exact_reg;
    assign err   = err_reg;
`ifdef INV_FACT_REM_EN
    assign rem   = rem_reg;
`endif

endmodule

// File: tb/tb_inv_factorial_seq.sv
module tb_inv_factorial_seq;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] n_out;
    logic             exact;
    logic             err;
`ifdef INV_FACT_REM_EN
    logic [WIDTH-1:0] rem;
`endif

    inv_factorial_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .n_out (n_out),
        .exact (exact),
        .err   (err)
`ifdef INV_FACT_REM_EN
        ,
        .rem   (rem)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    longint unsigned fact [0:20];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: use a table of true factorials and pick the largest
    // n >= 1 with n! <= V.
    task automatic model(input logic [WIDTH-1:0] v, output int n, output bit ex,
                         output bit er, output longint unsigned r);
        n  = 0;
        ex = 0;
        er = (v == 0);
        r  = 0;
        if (!er) begin
            for (int i = 1; i <= 20; i++)
                if (fact[i] <= longint'(v)) n = i;
            ex = (fact[n] == longint'(v));
            r  = longint'(v) - fact[n];
        end
    endtask

    // One full transaction. If hold_start is set, start stays high for the
    // whole run and value keeps changing.
    task automatic run_one(input logic [WIDTH-1:0] v, input bit hold_start);
        int n; bit ex; bit er; longint unsigned r;
        int cycles;
        model(v, n, ex, er, r);
        value = v;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        cycles = 1;
        check("busy_after_start", busy, 1);
        while (!done && cycles < 100) begin
            if (hold_start) value = $urandom;
            @(posedge clk); #1;
            cycles++;
            if (!done) check("busy_during_run", busy, 1);
        end
        check("timeout", (cycles >= 100), 0);
        check("latency", cycles + 1, er ? 2 : n + 2);
        check("n_out", n_out, n);
        check("exact", exact, ex);
        check("err", err, er);
`ifdef INV_FACT_REM_EN
        check("rem", rem, r);
`endif
        $display("txn value=%0d n=%0d exact=%0d err=%0d latency=%0d", v, n_out, exact, err, cycles + 1);
        if (!hold_start) begin
            @(posedge clk); #1;
            check("done_one_pulse", done, 0);
            check("idle_busy", busy, 0);
            check("n_out_held", n_out, n);
        end
    endtask

    initial begin
        int sel, idx;
        logic [WIDTH-1:0] v;
        fact[0] = 1;
        for (int i = 1; i <= 20; i++) fact[i] = fact[i-1] * longint'(i);

        rst_n = 1'b0;
        start = 1'b0;
        value = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_n_out", n_out, 0);
        check("rst_exact", exact, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        run_one(32'd24, 0);
        run_one(32'd720, 0);
        run_one(32'd100, 0);
        run_one(32'd1, 0);
        run_one(32'd0, 0);
        run_one(32'hFFFF_FFFF, 0);

        // Hold start through a run of 120. The next run must begin only
        // after the FSM has returned to idle.
        run_one(32'd120, 1);
        value = 32'd6;
        @(posedge clk); #1;
        check("held_start_idle_gap", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        check("held_start_restart", busy, 1);
        repeat (5) @(posedge clk);
        #1;
        check("held_start_n_out", n_out, 3);
        check("held_start_exact", exact, 1);

        // Pull reset low in the middle of CALC for 5040.
        value = 32'd5040;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_n_out", n_out, 0);
        check("async_rst_exact", exact, 0);
        begin
            bit saw_done = 0;
            repeat (10) begin
                @(posedge clk); #1;
                if (done) saw_done = 1;
            end
            rst_n = 1'b1;
            repeat (10) begin
                @(posedge clk); #1;
                if (done) saw_done = 1;
            end
            check("no_done_after_rst", saw_done, 0);
        end
        run_one(32'd6, 0);

        // Random runs.
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 3);
            idx = $urandom_range(1, 12);
            case (sel)
                0: v = $urandom;
                1: v = fact[idx][WIDTH-1:0];
                2: v = fact[idx][WIDTH-1:0] + (($urandom_range(0, 1) == 1) ? 32'd1 : 32'hFFFF_FFFF);
                default: v = $urandom_range(0, 50);
            endcase
            run_one(v, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
